instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entry count; only 2 is required.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  read request to instruction ROM, held until imem_ack.
REQ-006 imem_addr  output  32  word-aligned fetch byte address, stable while imem_req=1.
REQ-007 imem_ack  input  1  ROM response strobe, arriving 1 or more cycles after the request is accepted.
REQ-008 imem_rdata  input  32  ROM instruction word, valid when imem_ack=1.
REQ-009 inst  output  32  instruction presented to the control unit.
REQ-010 inst_pc  output  32  byte address of inst.
REQ-011 inst_valid  output  1  inst/inst_pc hold a live instruction.
REQ-012 inst_ready  input  1  control unit consumes inst this cycle.
REQ-013 PCsrc  input  1  taken-branch redirect strobe from the control unit.
REQ-014 redirect_pc  input  32  branch target, sampled when PCsrc=1; bits [1:0] are forced to 00.

Function
REQ-015 fetch_pc SHALL advance by 4 on each accepted imem_ack (not discarded), wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 At most one ROM request SHALL be outstanding at any time.
REQ-017 FSM states SHALL be IDLE (no request), WAIT (request outstanding), and DROP (outstanding request to be discarded).
REQ-018 IDLE->WAIT SHALL occur when buffer occupancy plus outstanding count < BUF_DEPTH and PCsrc=0, asserting imem_req with imem_addr=fetch_pc in the same cycle.
REQ-019 In WAIT on imem_ack with PCsrc=0, the block SHALL push {imem_rdata, imem_addr} into the buffer and go to IDLE, or stay in WAIT with a new request if space remains.
REQ-020 The buffer SHALL be a FIFO; inst/inst_pc SHALL come from the head entry and inst_valid SHALL equal non-empty.
REQ-021 Pop SHALL occur when inst_valid=1 and inst_ready=1; inst/inst_pc SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged, including when the buffer is full.
REQ-023 The fetch-to-inst_valid latency SHALL be 1 cycle after imem_ack (registered output, no combinational rdata->inst path).
REQ-024 On PCsrc=1, the block SHALL flush the buffer (inst_valid=0 next cycle) and set fetch_pc={redirect_pc[31:2],2'b00}.
REQ-025 On PCsrc=1 in WAIT without imem_ack, the FSM SHALL go to DROP; in DROP, imem_req SHALL be deasserted, the arriving ack SHALL be ignored, and the FSM SHALL then go to IDLE.
REQ-026 On PCsrc=1 coinciding with imem_ack, the returned word SHALL be discarded and the FSM SHALL go to IDLE.
REQ-027 On PCsrc=1 coinciding with a pop, the flush SHALL win and no stale instruction SHALL be presented.
REQ-028 PCsrc=1 in DROP SHALL update fetch_pc again and the FSM SHALL remain in DROP until the ack arrives.

Reset
REQ-029 When reset=0 at a clock edge: FSM=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; an imem_ack arriving on the first cycle after reset release SHALL be ignored (a DROP-equivalent flag is set by reset).
REQ-031 The first imem_req after reset SHALL assert on the first cycle after reset returns to 1.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE, WAIT, DROP), the constant INST_W=32, and the constant PC_STEP=4.
REQ-033 The buffer SHALL be one sub-module, fetch_buf, a 2-entry synchronous FIFO of {inst, pc} with push, pop, flush, full, and empty signals.

Verification
REQ-034 Reset release, ROM ack latency 1, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc follows 0,4,8 with inst equal to the ROM contents.
REQ-035 inst_ready=0 for 10 cycles -> 2 entries buffered, imem_req=0, inst stable at pc 0; on release, pc 0,4,8 in order with no gap or duplicate.
REQ-036 PCsrc=1 with redirect_pc=32'h40 while ack is outstanding (latency 3) -> stale word dropped; next imem_addr=32'h40; first inst_pc after flush=32'h40.
REQ-037 PCsrc=1 with redirect_pc=32'h103 in the same cycle as imem_ack -> word discarded; imem_addr=32'h100 next.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> fetches at FFFF_FFF8, FFFF_FFFC, then 0000_0000.
REQ-039 reset=0 asserted while in WAIT, with ack arriving the cycle after release -> ack ignored, inst_valid stays 0, fresh request issued to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package instr_fetch_unit_pkg;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } buf_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buf.sv
// Small synchronous FIFO of {inst, pc} entries; flush empties it and wins over push/pop.
module fetch_buf
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  buf_entry_t                     wdata,
    output buf_entry_t                     rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    buf_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push && !flush) mem_q[wr_q] <= wdata;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding ROM read at a time, feeding a small buffer toward the control unit.
//   state | meaning
//   IDLE  | no ROM request outstanding
//   WAIT  | request outstanding, imem_req held until imem_ack
//   DROP  | outstanding request was redirected away; its ack is discarded
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              PCsrc,
    input  logic [31:0]       redirect_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          ign_q;
    logic          ack_ok;
    logic          buf_push, buf_pop, buf_full, buf_empty;
    logic [CW-1:0] occ;
    logic [CW:0]   occ_after;
    buf_entry_t    buf_wdata, buf_rdata;

    // An ack seen right after reset belongs to a request abandoned by that reset.
    assign ack_ok    = imem_ack & ~ign_q;
    assign buf_pop   = inst_valid & inst_ready;
    assign occ_after = {1'b0, occ} + (CW+1)'(1) - (CW+1)'(buf_pop);
    assign buf_wdata = '{inst: imem_rdata, pc: pc_q};
    assign imem_addr = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        buf_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (!buf_full && !PCsrc) begin
                    imem_req = reset;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                imem_req = reset;
                if (ack_ok) begin
                    if (PCsrc) begin
                        state_d = IDLE;
                    end else begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + 32'(PC_STEP);
                        state_d  = (occ_after < (CW+1)'(BUF_DEPTH)) ? WAIT : IDLE;
                    end
                end else if (PCsrc) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (PCsrc) pc_d = redirect_pc & ~32'h3;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ign_q   <= 1'b0;
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (PCsrc),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occ)
    );

    assign inst       = buf_rdata.inst;
    assign inst_pc    = buf_rdata.pc;
    assign inst_valid = ~buf_empty;

endmodule
